// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// synchronous flush, registered read data with a valid strobe, and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   w_data, w_inc     - write data and write request (dropped while full)
//   r_inc             - read request (dropped while empty)
//   flush             - empties the FIFO next cycle, error flags untouched
//   err_clr           - clears overflow/underflow (a same-cycle set wins)
//   r_data, r_valid   - popped data; r_valid pulses the cycle after a pop
//   full, empty, almost_full, almost_empty, count - status from registered count
//   overflow, underflow - sticky error flags
//
// Optional feature macro SYNC_FIFO_FWFT_EN: when defined, the head entry is
// presented combinationally on r_data with r_valid = ~empty (zero read
// latency). r_inc then acknowledges the head entry.

module sync_fifo_buf #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_inc,
  input  logic                  r_inc,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Pointers carry one extra MSB so they wrap modulo 2*FIFO_DEPTH.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_acc, rd_acc;
  logic ovf_set, unf_set;

  // Status decodes straight off the registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == ZERO_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Reset and flush both swallow requests; a swallowed request is not an error.
  assign wr_acc  = w_inc & ~full  & ~flush & ~rst;
  assign rd_acc  = r_inc & ~empty & ~flush & ~rst;
  assign ovf_set = w_inc & full  & ~flush;
  assign unf_set = r_inc & empty & ~flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = ZERO_C;
      rd_ptr_d = ZERO_C;
      count_d  = ZERO_C;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    // Set beats clear when both happen together.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end
    if (unf_set) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= ZERO_C;
      rd_ptr_q    <= ZERO_C;
      count_q     <= ZERO_C;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry falls through; contents are meaningless while empty.
  assign r_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign r_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = rd_acc;
    if (rd_acc) begin
      r_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_buf.sv
module tb_sync_fifo_buf;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] w_data;
  logic          w_inc;
  logic          r_inc;
  logic          flush;
  logic          err_clr;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  sync_fifo_buf #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_data       (w_data),
    .w_inc        (w_inc),
    .r_inc        (r_inc),
    .flush        (flush),
    .err_clr      (err_clr),
    .r_data       (r_data),
    .r_valid      (r_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Reference model: the FIFO contents as a queue plus the visible registers.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_ovf;
  logic          m_unf;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the model by the same edge.
  task automatic step(input bit r_st, input bit w, input logic [DW-1:0] wd,
                      input bit r, input bit fl, input bit ec);
    int  sz;
    bit  was_full, was_empty;
    rst     = r_st;
    w_inc   = w;
    w_data  = wd;
    r_inc   = r;
    flush   = fl;
    err_clr = ec;
    @(posedge clk);
    sz        = m_q.size();
    was_full  = (sz == D);
    was_empty = (sz == 0);
    if (r_st) begin
      m_q.delete();
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      if (fl) begin
        m_q.delete();
        m_rvalid = 1'b0;
      end else begin
        m_rvalid = 1'b0;
        if (r && !was_empty) begin
          m_rdata = m_q.pop_front();
          sb_q.push_back(m_rdata);
          m_rvalid = 1'b1;
        end
        if (w && !was_full) m_q.push_back(wd);
      end
      if (!fl && w && was_full)       m_ovf = 1'b1;
      else if (ec)                    m_ovf = 1'b0;
      if (!fl && r && was_empty)      m_unf = 1'b1;
      else if (ec)                    m_unf = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: checks status against the model and pops the scoreboard on r_valid.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count",        count,        m_q.size());
      check("full",         full,         m_q.size() == D);
      check("empty",        empty,        m_q.size() == 0);
      check("almost_full",  almost_full,  m_q.size() >= D - 2);
      check("almost_empty", almost_empty, m_q.size() <= 2);
      check("overflow",     overflow,     m_ovf);
      check("underflow",    underflow,    m_unf);
      check("r_valid",      r_valid,      m_rvalid);
      if (r_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underrun: r_valid=1 with no expected entry at %0t", $time);
        end else begin
          check("r_data", r_data, sb_q.pop_front());
        end
      end else begin
        check("r_data_hold", r_data, m_rdata);
      end
    end
  end

  initial begin
    rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; flush = 1'b0; err_clr = 1'b0; w_data = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_r_data", r_data, 0);

    // Fill to full.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    check("fill_full", full, 1);
    check("fill_count", count, 8);

    // Drain in order.
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    check("drain_empty", empty, 1);
    check("drain_last_data", r_data, 8'h08);

    // Hold occupancy at 3 across the pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    check("wrap_count", count, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    check("wrap_tail", r_data, 8'h33);

    // Full with simultaneous write and read: read wins, overflow sets.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    check("ovf_count", count, 7);
    check("ovf_flag", overflow, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 0);

    // Drain, then empty with simultaneous write and read: write wins.
    for (int i = 0; i < D - 1; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("unf_flag", underflow, 1);
    check("unf_count", count, 1);
    check("unf_r_valid", r_valid, 0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("unf_next_valid", r_valid, 1);
    check("unf_next_data", r_data, 8'hAA);

    // Flush at count 5 with a concurrent write; underflow must survive.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_keeps_unf", underflow, 1);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("post_flush_data", r_data, 8'h55);

    // Randomised phases with varying write/read bias.
    for (int ph = 0; ph < 4; ph++) begin
      int wp, rp;
      wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 55;
      rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
      for (int c = 0; c < 600; c++) begin
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < wp,
             8'($urandom),
             $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 4);
      end
    end

    idle();
    idle();
    check("scoreboard_drained", sb_q.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
Single-clock parametrised FIFO: storage, read/write pointers, occupancy count and status flags in one block. It replaces separate memory/pointer blocks for intra-domain buffering, e.g. between the register file, the ALU and the UART TX path. It adds occupancy output, almost-full/almost-empty thresholds, synchronous flush, registered read data with a valid strobe, and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
FIFO_DEPTH, 8, number of entries; must be a power of 2, >= 2
ADDR_WIDTH, $clog2(FIFO_DEPTH), storage address width; derived, do not override
AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= this
AEMPTY_THRESH, 2, almost_empty asserts when count <= this

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
w_data  in  DATA_WIDTH  write data
w_inc  in  1  write request
r_inc  in  1  read request
flush  in  1  synchronous flush: empties the FIFO, keeps error flags
err_clr  in  1  clears overflow/underflow
r_data  out  DATA_WIDTH  read data, registered
r_valid  out  1  r_data holds a newly popped entry (see Behaviour)
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - Pointers and count = 0.
  - r_data = 0, r_valid = 0.
  - empty = 1, full = 0.
  - almost_empty = 1; almost_full = (AFULL_THRESH == 0).
  - overflow = 0, underflow = 0.
  - Storage array is not reset; contents are don't-care until written.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address storage.
  - The extra MSB gives wrap detection; pointers wrap modulo 2*FIFO_DEPTH.
- Write acceptance:
  - wr_acc = w_inc & ~full, using full from the current (registered) state.
  - On acceptance, mem[wr_ptr] <= w_data and wr_ptr increments.
- Read acceptance:
  - rd_acc = r_inc & ~empty, using empty from the current state.
  - On acceptance, r_data <= mem[rd_ptr] and rd_ptr increments.
  - r_valid is 1 in the cycle after rd_acc, otherwise 0. Read latency is 1 cycle.
  - r_data holds its last value when no read is accepted.
- Count: count_next = count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Flags (full, empty, almost_*) are combinational decodes of the registered count; no extra latency.
- Boundary cases:
  - Full + w_inc + r_inc: the read is accepted and the write is rejected. overflow sets; count becomes FIFO_DEPTH-1.
  - Empty + w_inc + r_inc: the write is accepted and the read is rejected (no bypass). underflow sets; count becomes 1; r_valid stays 0.
  - Wrap: after 2*FIFO_DEPTH accepted writes, wr_ptr returns to 0. Data order is preserved across the wrap.
- Error flags:
  - overflow sets on w_inc & full; underflow sets on r_inc & empty.
  - Both clear only on rst or err_clr.
  - If err_clr and a set condition occur in the same cycle, set wins.
- Flush:
  - Pointers and count go to 0 and r_valid goes to 0 in the next cycle.
  - Any w_inc or r_inc in the flush cycle is ignored and raises no error flags.
  - r_data holds its value.
- rst has priority over flush; flush has priority over reads and writes.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - r_data always presents mem[rd_ptr] whenever the FIFO is not empty; r_valid = ~empty.
  - r_inc acknowledges the head entry; the next entry appears in the following cycle.
  - Read latency is 0. r_data is don't-care while empty.
- Undefined: standard registered-read behaviour as described above.

Test Plan:
- Reset, then 8 writes 0x01..0x08 with no reads -> count=8, full=1, almost_full asserted from count=6, empty=0.
- From full, 8 reads -> r_data 0x01..0x08, each with r_valid one cycle after r_inc. Ends with empty=1, almost_empty=1 from count=2.
- 20 writes interleaved with reads, holding count at 3, to cross the pointer wrap -> output sequence identical to input; count stays 3 throughout.
- Full + simultaneous w_inc/r_inc -> count=7, overflow=1. Then err_clr=1 -> overflow=0 next cycle.
- Empty + simultaneous w_inc=0xAA / r_inc -> underflow=1, count=1, r_valid=0. The next r_inc returns 0xAA.
- Flush at count=5 with concurrent w_inc -> next cycle count=0, empty=1, and the flush-cycle write is not stored. The error flags are unchanged.
